// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared store-size/state types and word constants for the store data unit
package cpu_pkg;

  localparam int WORD_BYTES = 4;

  // Store access widths as encoded by the control FSM; 2'b11 is handled as a word.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } st_size_e;

  // Store port sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10,
    ST_ERR  = 2'b11
  } st_state_e;

endpackage

// File: rtl/store_lane_align.sv
// rtl/store_lane_align.sv - maps a store size/offset/data onto little-endian byte lanes
module store_lane_align
  import cpu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr,
  input  logic [31:0] data,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  output logic        misaligned
);

  // Place the low byte/half of data in the addressed lanes; unused lanes stay zero.
  always_comb begin
    writedata  = 32'h0;
    byteenable = 4'b0000;
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: begin
        writedata  = {24'h0, data[7:0]} << {addr, 3'b000};
        byteenable = 4'b0001 << addr;
      end
      SZ_HALF: begin
        misaligned = addr[0];
        if (addr[1]) begin
          writedata  = {data[15:0], 16'h0};
          byteenable = 4'b1100;
        end else begin
          writedata  = {16'h0, data[15:0]};
          byteenable = 4'b0011;
        end
      end
      default: begin
        misaligned = (addr != 2'b00);
        writedata  = data;
        byteenable = 4'b1111;
      end
    endcase
  end

endmodule

// File: rtl/store_data_unit.sv
// rtl/store_data_unit.sv - SB/SH/SW store port driving one Avalon write; STORE_TIMEOUT_EN adds a stall abort
module store_data_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  st_start,
  input  logic [1:0]            st_size,
  input  logic [ADDR_WIDTH-1:0] st_addr,
  input  logic [31:0]           st_data,
  input  logic                  mem_waitrequest,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_write,
  output logic [31:0]           mem_writedata,
  output logic [3:0]            mem_byteenable,
  output logic                  st_busy,
  output logic                  st_done,
  output logic                  st_err
);

  localparam int OFS_W = $clog2(WORD_BYTES);

  st_state_e   state;
  logic [31:0] lane_data;
  logic [3:0]  lane_be;
  logic        lane_mis;

`ifdef STORE_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] stall_cnt;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
`endif

  store_lane_align u_align (
    .size       (st_size),
    .addr       (st_addr[1:0]),
    .data       (st_data),
    .writedata  (lane_data),
    .byteenable (lane_be),
    .misaligned (lane_mis)
  );

  // Store FSM: accept a request in IDLE, hold the write through waitrequest, pulse done/err.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      mem_address    <= '0;
      mem_write      <= 1'b0;
      mem_writedata  <= 32'h0;
      mem_byteenable <= 4'b0000;
      st_busy        <= 1'b0;
      st_done        <= 1'b0;
      st_err         <= 1'b0;
`ifdef STORE_TIMEOUT_EN
      stall_cnt      <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          st_done <= 1'b0;
          st_err  <= 1'b0;
          if (st_start) begin
            if (lane_mis) begin
              st_err <= 1'b1;
              state  <= ST_ERR;
            end else begin
              mem_address    <= {st_addr[ADDR_WIDTH-1:OFS_W], {OFS_W{1'b0}}};
              mem_writedata  <= lane_data;
              mem_byteenable <= lane_be;
              mem_write      <= 1'b1;
              st_busy        <= 1'b1;
              state          <= ST_REQ;
`ifdef STORE_TIMEOUT_EN
              stall_cnt      <= '0;
`endif
            end
          end
        end
        ST_REQ: begin
          if (!mem_waitrequest) begin
            mem_write      <= 1'b0;
            mem_byteenable <= 4'b0000;
            st_busy        <= 1'b0;
            st_done        <= 1'b1;
            state          <= ST_DONE;
          end
`ifdef STORE_TIMEOUT_EN
          else if (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            mem_write      <= 1'b0;
            mem_byteenable <= 4'b0000;
            st_busy        <= 1'b0;
            st_err         <= 1'b1;
            state          <= ST_ERR;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
          end
`endif
        end
        ST_DONE: begin
          st_done <= 1'b0;
          state   <= ST_IDLE;
        end
        default: begin
          st_err <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_data_unit.sv
// tb/tb_store_data_unit.sv - randomized self-checking bench for store_data_unit (STORE_TIMEOUT_EN aware)
module tb_store_data_unit;

`ifdef STORE_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        st_start;
  logic [1:0]  st_size;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        mem_waitrequest;
  logic [31:0] mem_address;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteenable;
  logic        st_busy;
  logic        st_done;
  logic        st_err;

  int passed = 0;
  int total  = 0;

  // observations of the most recent transaction
  int          o_wcnt, o_dcnt, o_ecnt, o_bcnt, o_done_at, o_err_at;
  logic [31:0] o_addr, o_wd;
  logic [3:0]  o_be;
  bit          o_stable;

  store_data_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .st_start(st_start), .st_size(st_size),
    .st_addr(st_addr), .st_data(st_data), .mem_waitrequest(mem_waitrequest),
    .mem_address(mem_address), .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_byteenable(mem_byteenable), .st_busy(st_busy), .st_done(st_done), .st_err(st_err)
  );

  always #5 clk = ~clk;

  // Reference: lanes computed arithmetically from the store rules.
  function automatic void ref_store(input int size, input logic [31:0] addr, input logic [31:0] data,
                                    output logic [31:0] wd, output logic [3:0] be, output bit mis);
    int k;
    int base;
    k = int'(addr % 4);
    if (size == 0) begin
      mis = 0; wd = (data & 32'hFF) << (8 * k); be = 4'(1 << k);
    end else if (size == 1) begin
      base = (k / 2) * 2;
      mis = (k % 2) != 0; wd = (data & 32'hFFFF) << (8 * base); be = 4'(3 << base);
    end else begin
      mis = (k != 0); wd = data; be = 4'hF;
    end
  endfunction

  // Issue one request, hold waitrequest for `stall` write cycles, and record what the port did.
  task automatic run_store(input int size, input logic [31:0] addr, input logic [31:0] data,
                           input int stall, input bit poke);
    @(posedge clk); #1;
    st_start = 1'b1; st_size = 2'(size); st_addr = addr; st_data = data;
    mem_waitrequest = (stall > 0);
    o_wcnt = 0; o_dcnt = 0; o_ecnt = 0; o_bcnt = 0; o_done_at = -1; o_err_at = -1; o_stable = 1;
    o_addr = '0; o_wd = '0; o_be = '0;
    @(posedge clk); #1;
    for (int c = 1; c <= stall + 6; c++) begin
      st_start = poke && (c == 2);
      if (poke && c == 2) begin st_addr = 32'h0000_7777; st_data = 32'h5555_5555; st_size = 2'd0; end
      @(negedge clk);
      if (mem_write) begin
        if (o_wcnt == 0) begin o_addr = mem_address; o_wd = mem_writedata; o_be = mem_byteenable; end
        else if (mem_address !== o_addr || mem_writedata !== o_wd || mem_byteenable !== o_be) o_stable = 0;
        o_wcnt++;
      end
      if (st_busy) o_bcnt++;
      if (st_done) begin o_dcnt++; if (o_done_at < 0) o_done_at = c; end
      if (st_err) begin o_ecnt++; if (o_err_at < 0) o_err_at = c; end
      @(posedge clk); #1;
      mem_waitrequest = (o_wcnt < stall);
    end
    st_start = 1'b0;
    mem_waitrequest = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; st_start = 0; st_size = 0; st_addr = 0; st_data = 0; mem_waitrequest = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if ({mem_address, mem_write, mem_writedata, mem_byteenable, st_busy, st_done, st_err} !== '0)
      $display("FAIL reset_outputs: got addr=%h wr=%b wd=%h be=%b busy=%b done=%b err=%b expected all zero",
               mem_address, mem_write, mem_writedata, mem_byteenable, st_busy, st_done, st_err);
    else passed++;
    #2 reset = 1'b1;
  endtask

  task automatic test_sw();
    run_store(2, 32'h0000_1008, 32'hDEAD_BEEF, 0, 0);
    total++; if (o_addr !== 32'h0000_1008) $display("FAIL sw_addr: got %h expected 00001008", o_addr); else passed++;
    total++; if (o_be !== 4'hF) $display("FAIL sw_be: got %b expected 1111", o_be); else passed++;
    total++; if (o_wd !== 32'hDEAD_BEEF) $display("FAIL sw_wd: got %h expected deadbeef", o_wd); else passed++;
    total++; if (o_wcnt !== 1) $display("FAIL sw_write_cycles: got %0d expected 1", o_wcnt); else passed++;
    total++; if (o_done_at !== 2 || o_dcnt !== 1) $display("FAIL sw_done: got at=%0d n=%0d expected at=2 n=1", o_done_at, o_dcnt); else passed++;
    total++; if (o_ecnt !== 0) $display("FAIL sw_err: got %0d expected 0", o_ecnt); else passed++;
  endtask

  task automatic test_sb_sweep();
    logic [3:0]  be_tab [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [31:0] wd_tab [4] = '{32'h0000_00A5, 32'h0000_A500, 32'h00A5_0000, 32'hA500_0000};
    for (int k = 0; k < 4; k++) begin
      run_store(0, 32'h0000_2000 + k, 32'h0000_00A5, 0, 0);
      total++; if (o_be !== be_tab[k] || o_wd !== wd_tab[k] || o_addr !== 32'h0000_2000)
        $display("FAIL sb_lane%0d: got addr=%h wd=%h be=%b expected addr=00002000 wd=%h be=%b", k, o_addr, o_wd, o_be, wd_tab[k], be_tab[k]);
      else passed++;
      total++; if (o_dcnt !== 1 || o_wcnt !== 1) $display("FAIL sb_done%0d: got done=%0d writes=%0d expected 1/1", k, o_dcnt, o_wcnt); else passed++;
    end
  endtask

  task automatic test_sh();
    run_store(1, 32'h0000_3002, 32'h0000_1234, 0, 0);
    total++; if (o_be !== 4'b1100 || o_wd !== 32'h1234_0000 || o_addr !== 32'h0000_3000)
      $display("FAIL sh_upper: got addr=%h wd=%h be=%b expected 00003000/12340000/1100", o_addr, o_wd, o_be);
    else passed++;
    run_store(1, 32'h0000_3001, 32'h0000_1234, 0, 0);
    total++; if (o_wcnt !== 0) $display("FAIL sh_misaligned_write: got %0d write cycles expected 0", o_wcnt); else passed++;
    total++; if (o_ecnt !== 1 || o_err_at !== 1 || o_dcnt !== 0)
      $display("FAIL sh_misaligned_err: got err=%0d at=%0d done=%0d expected 1/1/0", o_ecnt, o_err_at, o_dcnt);
    else passed++;
    run_store(1, 32'h0000_3000, 32'hFFFF_ABCD, 0, 0);
    total++; if (o_be !== 4'b0011 || o_wd !== 32'h0000_ABCD || o_dcnt !== 1)
      $display("FAIL sh_after_err: got wd=%h be=%b done=%0d expected 0000abcd/0011/1", o_wd, o_be, o_dcnt);
    else passed++;
  endtask

  task automatic test_stall();
`ifdef STORE_TIMEOUT_EN
    int stall = 3;
`else
    int stall = 5;
`endif
    run_store(2, 32'h0000_5004, 32'hCAFE_F00D, stall, 1);
    total++; if (o_wcnt !== stall + 1) $display("FAIL stall_write_cycles: got %0d expected %0d", o_wcnt, stall + 1); else passed++;
    total++; if (!o_stable || o_addr !== 32'h0000_5004 || o_wd !== 32'hCAFE_F00D)
      $display("FAIL stall_stable: got stable=%0d addr=%h wd=%h expected 1/00005004/cafef00d", o_stable, o_addr, o_wd);
    else passed++;
    total++; if (o_dcnt !== 1 || o_done_at !== stall + 2)
      $display("FAIL stall_done: got n=%0d at=%0d expected 1 at %0d", o_dcnt, o_done_at, stall + 2);
    else passed++;
    total++; if (o_bcnt !== stall + 1) $display("FAIL stall_busy: got %0d expected %0d", o_bcnt, stall + 1); else passed++;
  endtask

  task automatic test_random();
    logic [31:0] addr, data, wd;
    logic [3:0]  be;
    bit          mis;
    int          size, stall;
    for (int i = 0; i < 24; i++) begin
      size  = int'($urandom_range(0, 3));
      addr  = $urandom;
      data  = $urandom;
      stall = int'($urandom_range(0, 3));
      ref_store(size, addr, data, wd, be, mis);
      run_store(size, addr, data, stall, 0);
      if (mis) begin
        total++; if (o_wcnt !== 0 || o_ecnt !== 1 || o_dcnt !== 0)
          $display("FAIL rand%0d_misaligned: got writes=%0d err=%0d done=%0d expected 0/1/0 (size=%0d addr=%h)",
                   i, o_wcnt, o_ecnt, o_dcnt, size, addr);
        else passed++;
      end else begin
        total++; if (o_addr !== (addr & 32'hFFFF_FFFC) || o_wd !== wd || o_be !== be)
          $display("FAIL rand%0d_lanes: got addr=%h wd=%h be=%b expected %h/%h/%b", i, o_addr, o_wd, o_be, addr & 32'hFFFF_FFFC, wd, be);
        else passed++;
        total++; if (o_wcnt !== stall + 1 || o_dcnt !== 1 || o_done_at !== stall + 2 || o_ecnt !== 0 || !o_stable)
          $display("FAIL rand%0d_handshake: got writes=%0d done=%0d at=%0d err=%0d stable=%0d expected %0d/1/%0d/0/1",
                   i, o_wcnt, o_dcnt, o_done_at, o_ecnt, o_stable, stall + 1, stall + 2);
        else passed++;
      end
    end
  endtask

  task automatic test_async_reset();
    int bad;
    @(posedge clk); #1;
    st_start = 1'b1; st_size = 2'd2; st_addr = 32'h0000_4000; st_data = 32'h1111_2222; mem_waitrequest = 1'b1;
    @(posedge clk); #1;
    st_start = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    total++; if (mem_write !== 1'b1) $display("FAIL areset_pre_write: got %b expected 1", mem_write); else passed++;
    reset = 1'b0;
    #1;
    total++; if ({mem_address, mem_write, mem_writedata, mem_byteenable, st_busy, st_done, st_err} !== '0)
      $display("FAIL areset_outputs: got addr=%h wr=%b wd=%h be=%b busy=%b expected all zero",
               mem_address, mem_write, mem_writedata, mem_byteenable, st_busy);
    else passed++;
    @(negedge clk); #2;
    reset = 1'b1; mem_waitrequest = 1'b0;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (st_done || st_err || mem_write) bad++;
    end
    total++; if (bad !== 0) $display("FAIL areset_no_pulse: got %0d active cycles expected 0", bad); else passed++;
  endtask

`ifdef STORE_TIMEOUT_EN
  task automatic test_timeout();
    run_store(2, 32'h0000_6000, 32'h0BAD_0BAD, 12, 0);
    total++; if (o_wcnt !== TO) $display("FAIL timeout_write_cycles: got %0d expected %0d", o_wcnt, TO); else passed++;
    total++; if (o_ecnt !== 1 || o_err_at !== TO + 1) $display("FAIL timeout_err: got n=%0d at=%0d expected 1 at %0d", o_ecnt, o_err_at, TO + 1); else passed++;
    total++; if (o_dcnt !== 0) $display("FAIL timeout_done: got %0d expected 0", o_dcnt); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_sw();
    test_sb_sweep();
    test_sh();
    test_stall();
    test_random();
    test_async_reset();
`ifdef STORE_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/store_data_unit.md
Name: store_data_unit

Overview:
- Store-side memory port of the multicycle MIPS CPU, in the opposite direction to the load-data capture register.
- Takes SB/SH/SW requests from the control FSM and registers a word-aligned address, lane-shifted write data and byteenable.
- Drives a single Avalon-style write and holds it until the memory drops waitrequest, then reports completion (or misalignment) to control.

Parameters:
- ADDR_WIDTH, 32, width of the byte address.
- TIMEOUT_CYCLES, 255, maximum waitrequest stall before abort; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- st_start  in  1  one-cycle request strobe from control; sampled only in IDLE.
- st_size  in  2  00=byte (SB), 01=half (SH), 10=word (SW); 11 is treated as word.
- st_addr  in  ADDR_WIDTH  byte address (rs + offset).
- st_data  in  32  rt value; the low byte/half is used for SB/SH.
- mem_waitrequest  in  1  memory stall.
- mem_address  out  ADDR_WIDTH  {st_addr[ADDR_WIDTH-1:2],2'b00}.
- mem_write  out  1  write strobe.
- mem_writedata  out  32  lane-aligned data.
- mem_byteenable  out  4  active lanes.
- st_busy  out  1  high in REQ.
- st_done  out  1  one-cycle pulse: write accepted.
- st_err  out  1  one-cycle pulse: misaligned request (or timeout, see below).

Behaviour:
- Reset (async, reset==0): state=IDLE. Outputs: mem_address=0, mem_write=0, mem_writedata=0, mem_byteenable=0, st_busy=0, st_done=0, st_err=0.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, REQ, DONE, ERR.
- IDLE with st_start=1 and aligned request: latch address, data and byteenable; go to REQ. mem_write=1 from the next cycle.
- IDLE with st_start=1 and misaligned request: go to ERR. mem_write stays 0; no memory access occurs.
- Misaligned means: SH with addr[0]=1, or SW with addr[1:0]!=0.
- Lane rules (little-endian lanes, k=addr[1:0]):
  - SB: byte k = st_data[7:0]; byteenable = 4'b0001<<k.
  - SH: addr[1]=0 gives lanes 1:0 = st_data[15:0], be=0011; addr[1]=1 gives lanes 3:2 = st_data[15:0], be=1100.
  - SW: writedata = st_data, be=1111.
  - Disabled lanes drive 0.
- REQ: mem_write, mem_address, mem_writedata and mem_byteenable stay stable while mem_waitrequest=1.
  - The first edge with mem_waitrequest=0 completes the transfer.
  - Next cycle: mem_write=0, mem_byteenable=0, state=DONE.
  - Minimum latency: start at edge N; mem_write high N+1..N+2; st_done high N+2..N+3.
- DONE: st_done=1 for one cycle, then IDLE.
- ERR: st_err=1 for one cycle, then IDLE.
- st_start outside IDLE is ignored; no queuing.
- In IDLE, DONE and ERR, mem_write=0.
- Reset asserted mid-REQ: mem_write drops immediately (async); no done/err pulse is produced.
- Register contents outside REQ hold their last values, except mem_write and mem_byteenable, which are 0.

Optional Feature:
- Macro STORE_TIMEOUT_EN.
- Defined:
  - An 8-bit+ counter (sized from TIMEOUT_CYCLES) counts REQ cycles with mem_waitrequest=1.
  - When it reaches TIMEOUT_CYCLES: drop mem_write, go to ERR, pulse st_err. No st_done.
  - The counter clears on entry to REQ and on reset.
- Undefined: no counter; REQ waits indefinitely on waitrequest.

Decomposition:
- Shared package (cpu_pkg) holds:
  - store-size enum (SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10);
  - store FSM state enum;
  - constant WORD_BYTES=4.
- One combinational sub-module, store_lane_align: inputs size, addr[1:0], data; outputs writedata, byteenable, misaligned. It is reusable by the bench as a reference model.

Test Plan:
- SW: addr=0x0000_1008, data=0xDEADBEEF, waitrequest=0 -> mem_address=0x1008, be=1111, wd=0xDEADBEEF, mem_write 1 cycle, st_done pulse 2 cycles after start.
- SB sweep: addr=0x2000..0x2003, data=0x000000A5 -> be=0001/0010/0100/1000, wd=0x000000A5/0x0000A500/0x00A50000/0xA5000000, mem_address=0x2000 each.
- SH at 0x3002, data=0x1234 -> be=1100, wd=0x12340000. SH at 0x3001 -> no mem_write, st_err pulse, then st_start accepted again.
- Stall: waitrequest=1 for 5 cycles, then 0 -> mem_write high 6 cycles with stable address/data/be; exactly one st_done; st_start asserted mid-REQ ignored.
- Async reset dropped mid-REQ (not on a clock edge) -> mem_write=0 at once, all outputs 0, no st_done after release.
- STORE_TIMEOUT_EN with TIMEOUT_CYCLES=4 and waitrequest stuck at 1 -> mem_write drops after 4 stalled cycles, st_err pulse, st_done never asserted.
